fp_divide_iterative: RTL and testbench

Single-precision IEEE-754 divider (out = in1 / in2). It is the inverse-operation companion to the pipelined FP multiplier and shares its flag set, flush-to-zero policy and rounding-mode encoding. It uses a radix-2 restoring divider driven by an FSM, taking one operation at a time with a ready/valid handshake.

---
 rtl/fp_divide_iterative.sv | 117 +++++++++++
 tb/tb_fp_divide_iterative.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_divide_iterative.sv
// fp_divide_iterative: IEEE-754 single divider, radix-2 restoring, one quotient bit per cycle.
module fp_divide_iterative #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_data_in,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  rounding_mode,
  output logic        ready,
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid_operation,
  output logic        divide_by_zero,
  output logic        valid_data_out
);
  localparam int CW = $clog2(QBITS);
  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND} state_t;
  state_t state, state_n;
  logic [24:0] rem, rem0, rem_n;
  logic [23:0] mb, ma, mb_in, diff;
  logic [QBITS-1:0] q;
  logic [CW-1:0] cnt;
  logic signed [9:0] exp_q, exp0, e_r;
  logic sign, special, sp_inv, sp_dbz, lt, ge, last;
  logic [2:0] rm;
  logic [31:0] sp_out, d_out, r_out;
  logic d_sp, d_inv, d_dbz, sgn;
  logic nan1, nan2, inf1, inf2, zero1, zero2;
  logic g, r, st, inx, up, to_inf, ovf, unf;
  logic [24:0] sum;
  assign sgn   = in1[31] ^ in2[31];
  assign nan1  = (&in1[30:23]) & (|in1[22:0]);
  assign nan2  = (&in2[30:23]) & (|in2[22:0]);
  assign inf1  = (&in1[30:23]) & ~(|in1[22:0]);
  assign inf2  = (&in2[30:23]) & ~(|in2[22:0]);
  assign zero1 = ~(|in1[30:23]);
  assign zero2 = ~(|in2[30:23]);
  // Denormals have a zero exponent field, so they decode as zero (flush-to-zero).
  always_comb begin
    d_sp  = 1'b1;
    d_out = 32'h0;
    d_inv = 1'b0;
    d_dbz = 1'b0;
    if (nan1 & in1[22]) d_out = in1;
    else if (nan2 & in2[22]) d_out = in2;
    else if (nan1) begin d_out = in1 | 32'h0040_0000; d_inv = 1'b1; end
    else if (nan2) begin d_out = in2 | 32'h0040_0000; d_inv = 1'b1; end
    else if ((inf1 & inf2) | (zero1 & zero2)) begin d_out = 32'h7FC0_0000; d_inv = 1'b1; end
    else if (inf1) d_out = {sgn, 8'hFF, 23'h0};
    else if (zero2) begin d_out = {sgn, 8'hFF, 23'h0}; d_dbz = 1'b1; end
    else if (zero1 | inf2) d_out = {sgn, 31'h0};
    else d_sp = 1'b0;
  end
  assign ma    = {1'b1, in1[22:0]};
  assign mb_in = {1'b1, in2[22:0]};
  assign lt    = ma < mb_in;
  assign rem0  = lt ? {ma, 1'b0} : {1'b0, ma};
  assign exp0  = 10'(in1[30:23]) - 10'(in2[30:23]) + 10'd127 - 10'(lt);
  assign ge    = rem >= {1'b0, mb};
  assign diff  = ge ? 24'(rem - {1'b0, mb}) : rem[23:0];
  assign rem_n = {diff, 1'b0};
  assign last  = cnt == CW'(QBITS - 1);
  assign g     = q[1];
  assign r     = q[0];
  assign st    = |rem;
  assign inx   = g | r | st;
  assign up    = rm == 3'd0 ? g & (r | st | q[2]) :
                 rm == 3'd4 ? g :
                 rm == 3'd3 ? inx & ~sign :
                 rm == 3'd2 ? inx & sign : 1'b0;
  assign sum   = {1'b0, q[QBITS-1:2]} + 25'(up);
  // sum[24:23] is 2'b01 normally and 2'b10 on significand carry-out.
  assign e_r    = exp_q + 10'(sum[24:23]) - 10'd1;
  assign ovf    = e_r >= 10'sd255;
  assign unf    = e_r <= 10'sd0;
  assign to_inf = rm == 3'd0 | rm == 3'd4 | (rm == 3'd3 & ~sign) | (rm == 3'd2 & sign);
  assign r_out  = ovf ? (to_inf ? {sign, 8'hFF, 23'h0} : {sign, 31'h7F7F_FFFF}) :
                  unf ? {sign, 31'h0} : {sign, e_r[7:0], sum[22:0]};
  assign ready  = state == IDLE;
  always_comb state_n = state == IDLE ? (valid_data_in ? (d_sp ? ROUND : DIVIDE) : IDLE) :
                        state == DIVIDE ? (last ? ROUND : DIVIDE) : IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0; mb <= '0; q <= '0; cnt <= '0; exp_q <= '0; sign <= 1'b0; rm <= '0;
      special <= 1'b0; sp_out <= '0; sp_inv <= 1'b0; sp_dbz <= 1'b0;
      out <= '0; overflow <= 1'b0; underflow <= 1'b0; inexact <= 1'b0;
      invalid_operation <= 1'b0; divide_by_zero <= 1'b0; valid_data_out <= 1'b0;
    end else begin
      valid_data_out <= 1'b0;
      if (state == IDLE && valid_data_in) begin
        rm <= rounding_mode; special <= d_sp; sp_out <= d_out; sp_inv <= d_inv; sp_dbz <= d_dbz;
        sign <= sgn; exp_q <= exp0; mb <= mb_in; rem <= rem0; cnt <= '0; q <= '0;
      end
      if (state == DIVIDE) begin
        rem <= rem_n;
        q   <= {q[QBITS-2:0], ge};
        cnt <= cnt + 1'b1;
      end
      if (state == ROUND) begin
        valid_data_out    <= 1'b1;
        out               <= special ? sp_out : r_out;
        overflow          <= ~special & ovf;
        underflow         <= ~special & ~ovf & unf;
        inexact           <= ~special & (inx | ovf | unf);
        invalid_operation <= special & sp_inv;
        divide_by_zero    <= special & sp_dbz;
      end
    end
  end
endmodule

// File: tb/tb_fp_divide_iterative.sv
// tb_fp_divide_iterative: directed vectors, corner sequences and random ops against an integer-division model.
module tb_fp_divide_iterative;
  logic clk = 1'b0, rst = 1'b1, valid_data_in = 1'b0;
  logic [31:0] in1 = '0, in2 = '0, out;
  logic [2:0] rounding_mode = '0;
  logic ready, overflow, underflow, inexact, invalid_operation, divide_by_zero, valid_data_out;
  int errors = 0, checks = 0;

  fp_divide_iterative dut (
    .clk(clk), .rst(rst), .valid_data_in(valid_data_in), .in1(in1), .in2(in2),
    .rounding_mode(rounding_mode), .ready(ready), .out(out), .overflow(overflow),
    .underflow(underflow), .inexact(inexact), .invalid_operation(invalid_operation),
    .divide_by_zero(divide_by_zero), .valid_data_out(valid_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  m;
    logic [31:0] o;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {overflow, underflow, inexact, invalid_operation, divide_by_zero};
  endfunction

  // Reference: one exact integer division, then the rounding rules applied arithmetically.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                                  output logic [31:0] o, output logic [4:0] f, output bit sp);
    bit s = a[31] ^ b[31];
    bit an = a[30:23] == 8'hFF && a[22:0] != 0, bn = b[30:23] == 8'hFF && b[22:0] != 0;
    bit ai = a[30:23] == 8'hFF && a[22:0] == 0, bi = b[30:23] == 8'hFF && b[22:0] == 0;
    bit az = a[30:23] == 0, bz = b[30:23] == 0;
    longint ma, mb, n, q, r;
    int e;
    bit g, rb, st, inx, up;
    sp = 1'b1;
    f = '0;
    o = '0;
    if (an && a[22]) o = a;
    else if (bn && b[22]) o = b;
    else if (an) begin o = a | 32'h0040_0000; f = 5'b00010; end
    else if (bn) begin o = b | 32'h0040_0000; f = 5'b00010; end
    else if ((ai && bi) || (az && bz)) begin o = 32'h7FC0_0000; f = 5'b00010; end
    else if (ai) o = {s, 8'hFF, 23'h0};
    else if (bz) begin o = {s, 8'hFF, 23'h0}; f = 5'b00001; end
    else if (az || bi) o = {s, 31'h0};
    else begin
      sp = 1'b0;
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
      if (ma < mb) begin n = ma << 26; e--; end
      else n = ma << 25;
      q = n / mb;
      r = n % mb;
      g = q[1]; rb = q[0]; st = r != 0;
      inx = g | rb | st;
      q = q >> 2;
      case (m)
        3'd0: up = g && (rb || st || q[0]);
        3'd2: up = inx && s;
        3'd3: up = inx && !s;
        3'd4: up = g;
        default: up = 1'b0;
      endcase
      q = q + longint'(up);
      if (q == (longint'(1) << 24)) begin q = longint'(1) << 23; e++; end
      if (e >= 255) begin
        f = 5'b10100;
        o = (m == 0 || m == 4 || (m == 3 && !s) || (m == 2 && s)) ? {s, 8'hFF, 23'h0} : {s, 31'h7F7F_FFFF};
      end else if (e <= 0) begin
        f = 5'b01100;
        o = {s, 31'h0};
      end else begin
        o = {s, 8'(e), q[22:0]};
        f = {2'b00, inx, 2'b00};
      end
    end
  endfunction

  // Called at posedge+1 with ready expected high; returns result, flags and edges from accept to valid_data_out.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] m,
                        output logic [31:0] o, output logic [4:0] f, output int lat, output bit rdy_bad);
    in1 = a; in2 = b; rounding_mode = m; valid_data_in = 1'b1;
    @(posedge clk); #1 valid_data_in = 1'b0;
    lat = 0; rdy_bad = 1'b0; o = 'x; f = 'x;
    while (lat < 60) begin
      @(posedge clk); #1 lat++;
      if (valid_data_out) begin o = out; f = flags(); break; end
      if (ready) rdy_bad = 1'b1;
    end
  endtask

  vec_t vt[16];
  logic [31:0] o, eo, a, b;
  logic [4:0] f, ef;
  logic [2:0] m;
  int lat, cnt;
  bit rb, sp;

  initial begin
    vt[0]  = '{32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 5'b00000, 27};
    vt[1]  = '{32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 5'b00100, 27};
    vt[2]  = '{32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 5'b00100, 27};
    vt[3]  = '{32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 5'b00100, 27};
    vt[4]  = '{32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 5'b00100, 27};
    vt[5]  = '{32'h3F800000, 32'h00000000, 3'd0, 32'h7F800000, 5'b00001, 1};
    vt[6]  = '{32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 5'b00010, 1};
    vt[7]  = '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00001, 5'b00010, 1};
    vt[8]  = '{32'hBF800000, 32'h7F800000, 3'd0, 32'h80000000, 5'b00000, 1};
    vt[9]  = '{32'h7F7FFFFF, 32'h3F000000, 3'd0, 32'h7F800000, 5'b10100, 27};
    vt[10] = '{32'h7F7FFFFF, 32'h3F000000, 3'd1, 32'h7F7FFFFF, 5'b10100, 27};
    vt[11] = '{32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 5'b01100, 27};
    vt[12] = '{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 5'b00000, 1};
    vt[13] = '{32'h7FC00000, 32'h7F800001, 3'd0, 32'h7FC00000, 5'b00000, 1};
    vt[14] = '{32'hBF800000, 32'h00000000, 3'd0, 32'hFF800000, 5'b00001, 1};
    vt[15] = '{32'hC0C00000, 32'h40000000, 3'd4, 32'hC0400000, 5'b00000, 27};

    repeat (3) @(posedge clk);
    #1;
    chk("reset out", out, 32'h0);
    chk("reset flags", 32'(flags()), 32'h0);
    chk("reset valid", 32'(valid_data_out), 32'h0);
    chk("reset ready", 32'(ready), 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].m, o, f, lat, rb);
      chk($sformatf("vec%0d out", i), o, vt[i].o);
      chk($sformatf("vec%0d flags", i), 32'(f), 32'(vt[i].f));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d ready low while busy", i), 32'(rb), 32'h0);
    end

    for (int i = 0; i < 60; i++) begin
      int sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom; m = 3'($urandom_range(0, 4));
      if (sel < 6) begin
        a[30:23] = 8'($urandom_range(100, 155));
        b[30:23] = 8'($urandom_range(100, 155));
      end else if (sel == 6) begin
        a[30:23] = 8'($urandom_range(240, 254));
        b[30:23] = 8'($urandom_range(1, 20));
      end else if (sel == 7) begin
        a[30:23] = 8'($urandom_range(1, 20));
        b[30:23] = 8'($urandom_range(235, 254));
      end else if (sel == 8) begin
        a[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) a[22:0] = '0;
      end
      ref_div(a, b, m, eo, ef, sp);
      run_op(a, b, m, o, f, lat, rb);
      chk($sformatf("rand%0d out %h/%h m%0d", i, a, b, m), o, eo);
      chk($sformatf("rand%0d flags", i), 32'(f), 32'(ef));
      chk($sformatf("rand%0d latency", i), 32'(lat), sp ? 32'd1 : 32'd27);
    end

    in1 = 32'h3F800000; in2 = 32'h40400000; rounding_mode = 3'd0; valid_data_in = 1'b1;
    @(posedge clk); #1 valid_data_in = 1'b0;
    repeat (5) @(posedge clk);
    #1 in1 = 32'h40C00000; in2 = 32'h40000000; valid_data_in = 1'b1;
    @(posedge clk); #1 valid_data_in = 1'b0;
    cnt = 0; o = '0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_data_out) begin cnt++; o = out; end
    end
    chk("ignored in DIVIDE pulses", 32'(cnt), 32'd1);
    chk("ignored in DIVIDE out", o, 32'h3EAAAAAB);

    in1 = 32'h40C00000; in2 = 32'h40000000; rounding_mode = 3'd0; valid_data_in = 1'b1;
    @(posedge clk); #1 valid_data_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midreset out", out, 32'h0);
    chk("midreset flags", 32'(flags()), 32'h0);
    chk("midreset ready", 32'(ready), 32'h1);
    chk("midreset valid", 32'(valid_data_out), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (valid_data_out) cnt++;
    end
    chk("midreset no result", 32'(cnt), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 3'd0, o, f, lat, rb);
    chk("post reset out", o, 32'h40400000);
    chk("post reset flags", 32'(f), 32'h0);
    chk("post reset latency", 32'(lat), 32'd27);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
